// File: rtl/pi_screen_pkg.sv
// Shared screen geometry and types for the pi digit display path.
// Used by the prefetch sequencer, the video scanner and the glyph ROM.
//   COLS, ROWS : character grid (640x480 with 8x16 glyphs)
//   AW         : character RAM address width
//   digit_t    : one BCD digit
//   fsm_t      : prefetch sequencer states
package pi_screen_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int AW   = $clog2(COLS * ROWS);

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fsm_t;

endpackage

// File: rtl/pi_tag_delay.sv
// Fixed-latency tag pipe that tracks which screen cell each in-flight digit
// request belongs to. An entry pushed in cycle c appears on pop/pop_addr in
// cycle c+LAT.
// Ports:
//   clk, rst        clock, synchronous active-high clear
//   push, push_addr new entry {valid, cell address}
//   pop, pop_addr   entry leaving the pipe this cycle
//   any_valid       at least one entry in flight
module pi_tag_delay #(
    parameter int LAT = 6,
    parameter int AW  = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    output logic          pop,
    output logic [AW-1:0] pop_addr,
    output logic          any_valid
);

    logic [LAT-1:0] vld_q;
    logic [AW-1:0]  addr_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= push;
            addr_q[0] <= push_addr;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign pop       = vld_q[LAT-1];
    assign pop_addr  = addr_q[LAT-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/pi_digit_prefetch.sv
// Screen refill sequencer for pi_get_digit. Walks pi_index from base_index
// over COLS*ROWS digits, holding each index HOLD cycles, and writes each
// returned digit into the character RAM at its linear cell address.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | presenting indices to the getter, one per HOLD cycles
// DRAIN | all indices issued, waiting for in-flight digits to land
// DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         refill request (accepted only in IDLE)
//   base_index    first digit index, sampled on accepted start
//   busy, done    fill in progress / one-cycle completion pulse
//   pi_index      index to pi_get_digit
//   pi_digit      digit from pi_get_digit, LAT cycles after the last hold cycle
//   wr_en, wr_addr, wr_data   character RAM write port
module pi_digit_prefetch #(
    parameter int N    = 17,
    parameter int COLS = pi_screen_pkg::COLS,
    parameter int ROWS = pi_screen_pkg::ROWS,
    parameter int HOLD = 2,
    parameter int LAT  = 6,
    parameter int AW   = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  base_index,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  pi_index,
    input  logic [3:0]    pi_digit,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [3:0]    wr_data
);
    import pi_screen_pkg::*;

    localparam int CELLS = COLS * ROWS;
    localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [AW-1:0] CELL_LAST = AW'(CELLS - 1);

    fsm_t          state, state_nx;
    logic [HW-1:0] hold_cnt;
    logic [AW-1:0] cell_cnt;
    logic          hold_last;
    logic          push;
    logic          last_idx;
    logic          pop;
    logic [AW-1:0] pop_addr;
    logic          pipe_busy;
    digit_t        digit_in;

    assign digit_in  = pi_digit;
    assign hold_last = (hold_cnt == HOLD_LAST);
    assign push      = (state == ISSUE) && hold_last;
    assign last_idx  = push && (cell_cnt == CELL_LAST);

    pi_tag_delay #(
        .LAT (LAT),
        .AW  (AW)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (cell_cnt),
        .pop       (pop),
        .pop_addr  (pop_addr),
        .any_valid (pipe_busy)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (last_idx) state_nx = DRAIN;
            DRAIN:   if (!pipe_busy) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            pi_index <= '0;
            hold_cnt <= '0;
            cell_cnt <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ISSUE) || (state_nx == DRAIN);
            done  <= (state_nx == DONE);

            // The getter's digit for the popped tag is on pi_digit this cycle.
            wr_en <= pop;
            if (pop) begin
                wr_addr <= pop_addr;
                wr_data <= digit_in;
            end

            if (state == IDLE && start) begin
                pi_index <= base_index;
                hold_cnt <= '0;
                cell_cnt <= '0;
            end else if (state == ISSUE) begin
                if (hold_last) begin
                    hold_cnt <= '0;
                    // Natural N-bit wrap of the index is intended.
                    pi_index <= pi_index + N'(1);
                    cell_cnt <= cell_cnt + AW'(1);
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pi_digit_prefetch.sv
module tb_pi_digit_prefetch;

    localparam int HOLD = 2;
    localparam int LAT  = 6;
    localparam int K    = 8;
    localparam int DONE_AGE = K * HOLD + LAT + 2;   // 24 cycles start -> done
    localparam int FIRST_WR = HOLD + LAT + 1;       // first write, cycles after start

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a [2];
    logic [16:0] base_a  [2];

    logic        busy0, done0, wr_en0;
    logic [16:0] pidx0;
    logic [3:0]  dig0, wdata0;
    logic [2:0]  waddr0;

    logic        busy1, done1, wr_en1;
    logic [3:0]  pidx1, dig1, wdata1;
    logic [2:0]  waddr1;

    logic        start_d;
    logic [16:0] base_d;
    logic        busy_d, done_d, wr_en_d;
    logic [16:0] pidx_d;
    logic [3:0]  dig_d, wdata_d;
    logic [11:0] waddr_d;

    pi_digit_prefetch #(.N(17), .COLS(4), .ROWS(2), .HOLD(HOLD), .LAT(LAT)) dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .base_index(base_a[0]),
        .busy(busy0), .done(done0), .pi_index(pidx0), .pi_digit(dig0),
        .wr_en(wr_en0), .wr_addr(waddr0), .wr_data(wdata0));

    pi_digit_prefetch #(.N(4), .COLS(4), .ROWS(2), .HOLD(HOLD), .LAT(LAT)) dut1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .base_index(base_a[1][3:0]),
        .busy(busy1), .done(done1), .pi_index(pidx1), .pi_digit(dig1),
        .wr_en(wr_en1), .wr_addr(waddr1), .wr_data(wdata1));

    pi_digit_prefetch dut2 (
        .clk(clk), .rst(rst), .start(start_d), .base_index(base_d),
        .busy(busy_d), .done(done_d), .pi_index(pidx_d), .pi_digit(dig_d),
        .wr_en(wr_en_d), .wr_addr(waddr_d), .wr_data(wdata_d));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Decimal digits of pi after the point; index 0 -> 1.
    logic [3:0] ref_arr [256];

    // Behavioural pi_get_digit: digit of the index seen LAT cycles earlier.
    logic [16:0] hist0 [LAT];
    logic [16:0] hist1 [LAT];
    logic [16:0] histd [LAT];
    always @(posedge clk) begin
        hist0[0] <= pidx0;
        hist1[0] <= {13'd0, pidx1};
        histd[0] <= pidx_d;
        for (int k = 1; k < LAT; k++) begin
            hist0[k] <= hist0[k-1];
            hist1[k] <= hist1[k-1];
            histd[k] <= histd[k-1];
        end
    end
    always_comb begin
        dig0  = ref_arr[hist0[LAT-1][7:0]];
        dig1  = ref_arr[hist1[LAT-1][7:0]];
        dig_d = histd[LAT-1][3:0];   // deliberately includes values >9
    end

    logic [16:0] pidx_v [2];
    logic        busy_v [2], done_v [2], wen_v [2];
    logic [2:0]  wad_v  [2];
    logic [3:0]  wda_v  [2];
    assign pidx_v[0] = pidx0;            assign pidx_v[1] = {13'd0, pidx1};
    assign busy_v[0] = busy0;            assign busy_v[1] = busy1;
    assign done_v[0] = done0;            assign done_v[1] = done1;
    assign wen_v[0]  = wr_en0;           assign wen_v[1]  = wr_en1;
    assign wad_v[0]  = waddr0;           assign wad_v[1]  = waddr1;
    assign wda_v[0]  = wdata0;           assign wda_v[1]  = wdata1;

    function automatic logic [16:0] idx_mask(input int i);
        return (i == 0) ? 17'h1FFFF : 17'h0000F;
    endfunction

    // Model: a fill is "age" cycles old (age 1 = cycle after accepted start).
    int          cyc = 0;
    bit          act [2];
    int          age [2];
    logic [16:0] mbase [2];
    int          start_edge [2];
    int          wcount [2];
    int          done_count [2];
    int          done_cyc [2];
    logic [2:0]  wa_log [2][64];
    logic [3:0]  wd_log [2][64];
    int          wc_log [2][64];
    logic [16:0] pidx_age5 [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; age[i] = 0; mbase[i] = '0; start_edge[i] = 0;
            wcount[i] = 0; done_count[i] = 0; done_cyc[i] = 0; pidx_age5[i] = '0;
        end
    end

    always @(posedge clk) begin
        bit          e_busy, e_done, e_wen;
        int          off, j;
        logic [16:0] e_idx;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                act[i] = 1'b0;
            end else if (start_a[i] && !act[i]) begin
                act[i] = 1'b1; age[i] = 1; mbase[i] = base_a[i] & idx_mask(i);
                start_edge[i] = cyc;
            end else if (act[i]) begin
                if (age[i] == DONE_AGE) act[i] = 1'b0;
                else age[i]++;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            e_busy = act[i] && (age[i] < DONE_AGE);
            e_done = act[i] && (age[i] == DONE_AGE);
            off    = age[i] - FIRST_WR;
            j      = off / HOLD;
            e_wen  = act[i] && (off >= 0) && (off % HOLD == 0) && (j < K);
            chk("busy", busy_v[i], e_busy);
            chk("done", done_v[i], e_done);
            chk("wr_en", wen_v[i], e_wen);
            if (e_wen) begin
                e_idx = (mbase[i] + 17'(j)) & idx_mask(i);
                chk("wr_addr", wad_v[i], j);
                chk("wr_data", wda_v[i], ref_arr[e_idx[7:0]]);
            end
            if (act[i] && age[i] >= 1 && age[i] <= K * HOLD) begin
                e_idx = (mbase[i] + 17'((age[i] - 1) / HOLD)) & idx_mask(i);
                chk("pi_index", pidx_v[i], e_idx);
            end
            if (act[i] && age[i] == 5) pidx_age5[i] = pidx_v[i];
            if (wen_v[i] && wcount[i] < 64) begin
                wa_log[i][wcount[i]] = wad_v[i];
                wd_log[i][wcount[i]] = wda_v[i];
                wc_log[i][wcount[i]] = cyc;
            end
            if (wen_v[i]) wcount[i]++;
            if (done_v[i]) begin
                done_count[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    // Default-geometry fill tracker.
    bit          run_d = 1'b0;
    int          age_d = 0;
    int          wcnt_d = 0;
    int          last_addr_d = -1;
    int          done_age_d = 0;
    int          ddone_cnt = 0;
    logic [16:0] base_d_s = '0;
    always @(posedge clk) begin
        logic [16:0] e_idx;
        if (rst) begin
            run_d = 1'b0;
        end else if (start_d && !run_d) begin
            run_d = 1'b1; age_d = 1; wcnt_d = 0; base_d_s = base_d;
        end else if (run_d) begin
            age_d++;
        end
        #1;
        if (wr_en_d) begin
            e_idx = base_d_s + 17'(wcnt_d);
            chk("def_wr_addr", waddr_d, wcnt_d);
            chk("def_wr_data", wdata_d, e_idx[3:0]);
            last_addr_d = int'(waddr_d);
            wcnt_d++;
        end
        if (done_d && run_d) begin
            done_age_d = age_d;
            ddone_cnt++;
            run_d = 1'b0;
        end
    end

    task automatic pulse(input int i, input logic [16:0] b);
        @(negedge clk);
        base_a[i]  = b;
        start_a[i] = 1'b1;
        @(negedge clk);
        start_a[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int d0 = done_count[i];
        int n  = 0;
        while (done_count[i] == d0 && n < budget) begin
            @(posedge clk); #2; n++;
        end
        chk("done_seen", int'(done_count[i] != d0), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string pi_str;
        int w0, dc0, n;
        logic [3:0] basic_exp [8];
        pi_str = {"14159265358979323846264338327950288419716939937510",
                  "58209749445923078164062862089986280348253421170679",
                  "82148086513282306647093844609550582231725359408128",
                  "48111745028410270193852110555964462294895493038196"};
        for (int i = 0; i < 256; i++)
            ref_arr[i] = (i < pi_str.len()) ? 4'(pi_str[i] - 8'd48) : 4'd0;
        basic_exp = '{4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5};

        rst = 1'b1;
        start_a[0] = 1'b0; start_a[1] = 1'b0; base_a[0] = '0; base_a[1] = '0;
        start_d = 1'b0; base_d = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_wr_en", wr_en0, 0);
        chk("rst_wr_addr", waddr0, 0);
        chk("rst_wr_data", wdata0, 0);
        chk("rst_pi_index", pidx0, 0);
        chk("rst_def_busy", busy_d, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic fill from index 0
        w0 = wcount[0];
        pulse(0, 17'd0);
        wait_done(0, 200);
        chk("basic_count", wcount[0] - w0, 8);
        for (int j = 0; j < 8; j++) begin
            chk("basic_addr", wa_log[0][w0+j], j);
            chk("basic_data", wd_log[0][w0+j], basic_exp[j]);
        end
        for (int j = 0; j < 7; j++)
            chk("basic_gap", wc_log[0][w0+j+1] - wc_log[0][w0+j], 2);
        chk("basic_done_after_write", done_cyc[0] - wc_log[0][w0+7], 1);
        chk("basic_fill_time", done_cyc[0] - start_edge[0] + 1, 24);

        // Scroll: index 100 is the 101st decimal of pi (8)
        w0 = wcount[0];
        pulse(0, 17'd100);
        wait_done(0, 200);
        chk("scroll_count", wcount[0] - w0, 8);
        chk("scroll_first_data", wd_log[0][w0], 8);
        for (int j = 0; j < 8; j++) chk("scroll_addr", wa_log[0][w0+j], j);

        // Index wrap with a 4-bit index: 14,15,0,1,...
        w0 = wcount[1];
        pulse(1, 17'd14);
        wait_done(1, 200);
        chk("wrap_count", wcount[1] - w0, 8);
        chk("wrap_data0", wd_log[1][w0], 3);
        chk("wrap_data1", wd_log[1][w0+1], 2);
        chk("wrap_data2", wd_log[1][w0+2], 1);
        chk("wrap_pidx_age5", pidx_age5[1], 0);
        for (int j = 0; j < 8; j++) chk("wrap_addr", wa_log[1][w0+j], j);

        // Start pulses while busy are ignored
        w0 = wcount[0]; dc0 = done_count[0];
        pulse(0, 17'd0);
        repeat (3) @(negedge clk);
        base_a[0] = 17'd50; start_a[0] = 1'b1;
        @(negedge clk); start_a[0] = 1'b0;
        repeat (6) @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk); start_a[0] = 1'b0;
        wait_done(0, 200);
        repeat (30) @(negedge clk);
        chk("busy_start_count", wcount[0] - w0, 8);
        chk("busy_start_data0", wd_log[0][w0], 1);
        chk("busy_start_data7", wd_log[0][w0+7], 5);
        chk("busy_start_dones", done_count[0] - dc0, 1);

        // Reset after the 3rd write aborts the fill
        w0 = wcount[0]; dc0 = done_count[0]; n = 0;
        pulse(0, 17'd0);
        while (wcount[0] - w0 < 3 && n < 100) begin
            @(posedge clk); #2; n++;
        end
        chk("midrst_third_write", wcount[0] - w0, 3);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy", busy0, 0);
        repeat (30) @(negedge clk);
        chk("midrst_no_more_writes", wcount[0] - w0, 3);
        chk("midrst_no_done", done_count[0] - dc0, 0);
        w0 = wcount[0];
        pulse(0, 17'd0);
        wait_done(0, 200);
        chk("refill_count", wcount[0] - w0, 8);
        chk("refill_addr0", wa_log[0][w0], 0);
        chk("refill_addr7", wa_log[0][w0+7], 7);
        chk("refill_data7", wd_log[0][w0+7], 5);

        // Default geometry: 2400 cells, base near the top of the index range
        @(negedge clk);
        base_d = 17'h1FFF8; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        n = 0;
        while (ddone_cnt == 0 && n < 6000) begin
            @(posedge clk); #2; n++;
        end
        chk("def_done_seen", ddone_cnt, 1);
        chk("def_write_count", wcnt_d, 2400);
        chk("def_last_addr", last_addr_d, 2399);
        chk("def_fill_time", done_age_d, 4808);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
